// File: rtl/head_table_wr_ctrl_if.sv
// Head table write controller: shared sizing package and requester bundle.
// Requesters drive valid/addr/ptr; the controller returns a one-hot grant.
package ht_pkg;
    localparam int BUCKET_WIDTH   = 10;
    localparam int HEAD_PTR_WIDTH = 16;
endpackage

interface head_table_wr_ctrl_if #(
    parameter int A_WIDTH   = ht_pkg::BUCKET_WIDTH,
    parameter int PTR_WIDTH = ht_pkg::HEAD_PTR_WIDTH,
    parameter int REQ_CNT   = 2
);
    logic [REQ_CNT-1:0]           req_valid_i;
    logic [REQ_CNT*A_WIDTH-1:0]   req_addr_i;
    logic [REQ_CNT*PTR_WIDTH-1:0] req_ptr_i;
    logic [REQ_CNT-1:0]           req_ptr_val_i;
    logic [REQ_CNT-1:0]           req_ready_o;

    modport master (
        output req_valid_i, req_addr_i, req_ptr_i, req_ptr_val_i,
        input  req_ready_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_ptr_i, req_ptr_val_i,
        output req_ready_o
    );
endinterface

// File: rtl/head_table_wr_ctrl.sv
// Head table write-port owner: full-table clear walk, then round-robin
// arbitration of requester writes onto the single write port.
module head_table_wr_ctrl #(
    parameter int A_WIDTH   = ht_pkg::BUCKET_WIDTH,
    parameter int PTR_WIDTH = ht_pkg::HEAD_PTR_WIDTH,
    parameter int REQ_CNT   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    output logic                 init_done_o,
    head_table_wr_ctrl_if.slave  req,
    output logic [A_WIDTH-1:0]   wr_addr,
    output logic [PTR_WIDTH-1:0] wr_data_ptr,
    output logic                 wr_data_ptr_val,
    output logic                 wr_en
);
    localparam int LG_W = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t             state;
    state_t             state_nx;
    logic [A_WIDTH-1:0] clr_cnt;
    logic [LG_W-1:0]    last_grant;
    logic [REQ_CNT-1:0] grant;
    logic [REQ_CNT-1:0] ready;
    logic               found;
    logic               xfer;
    int                 idx;
    int                 gi;

    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            CLEAR: if (!clear_i && (&clr_cnt)) state_nx = RUN;
            RUN:   if (clear_i) state_nx = CLEAR;
            default: state_nx = CLEAR;
        endcase
    end

    // Search starts just after the last winner so every requester rotates.
    always_comb begin
        grant = '0;
        found = 1'b0;
        gi    = 0;
        idx   = 0;
        for (int k = 1; k <= REQ_CNT; k++) begin
            idx = (int'(last_grant) + k) % REQ_CNT;
            if (!found && req.req_valid_i[idx]) begin
                found      = 1'b1;
                gi         = idx;
                grant[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        ready = '0;
        if (state == RUN) ready = grant;
        xfer = |(req.req_valid_i & ready);
    end

    assign req.req_ready_o = ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt         <= '0;
            last_grant      <= LG_W'(REQ_CNT - 1);
            init_done_o     <= 1'b0;
            wr_en           <= 1'b0;
            wr_addr         <= '0;
            wr_data_ptr     <= '0;
            wr_data_ptr_val <= 1'b0;
        end else begin
            init_done_o <= (state_nx == RUN);
            wr_en       <= 1'b0;
            if (state == CLEAR) begin
                wr_en           <= 1'b1;
                wr_addr         <= clr_cnt;
                wr_data_ptr     <= '0;
                wr_data_ptr_val <= 1'b0;
                clr_cnt         <= clear_i ? '0 : clr_cnt + 1'b1;
            end else begin
                clr_cnt <= '0;
                if (xfer) begin
                    wr_en           <= 1'b1;
                    wr_addr         <= req.req_addr_i[gi*A_WIDTH +: A_WIDTH];
                    wr_data_ptr     <= req.req_ptr_i[gi*PTR_WIDTH +: PTR_WIDTH];
                    wr_data_ptr_val <= req.req_ptr_val_i[gi];
                    last_grant      <= LG_W'(gi);
                end
            end
        end
    end
endmodule

// File: doc/head_table_wr_ctrl.md
# head_table_wr_ctrl

Write-side controller for the hash table head table. Owns the head table write port and shares it between `REQ_CNT` requesters (insert/delete engines) by round-robin arbitration. After reset, and on request, it sequences a full-table clear that invalidates every bucket head pointer. No requester write is accepted until the clear completes.

## Interface
- `A_WIDTH`, default `BUCKET_WIDTH`: head table address width; `DEPTH = 2**A_WIDTH`.
- `PTR_WIDTH`, default `HEAD_PTR_WIDTH`: head pointer width.
- `REQ_CNT`, default 2: number of requesters, ≥1.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `clear_i`  in  1  single-cycle pulse that starts a full-table clear.
- `init_done_o`  out  1  high when no clear is running and requests are accepted.
- `req_valid_i`  in  `REQ_CNT`  per-requester write request.
- `req_addr_i`  in  `REQ_CNT*A_WIDTH`  bucket address; requester i occupies bits `[i*A_WIDTH +: A_WIDTH]`.
- `req_ptr_i`  in  `REQ_CNT*PTR_WIDTH`  head pointer, packed the same way.
- `req_ptr_val_i`  in  `REQ_CNT`  head pointer valid flag.
- `req_ready_o`  out  `REQ_CNT`  grant; one-hot or zero.
- `wr_addr`  out  `A_WIDTH`  head table write address.
- `wr_data_ptr`  out  `PTR_WIDTH`  head table write pointer.
- `wr_data_ptr_val`  out  1  head table pointer-valid bit.
- `wr_en`  out  1  head table write strobe.

## Operation
- The FSM has two states: CLEAR and RUN.
- CLEAR:
  - A counter `clr_cnt` (A_WIDTH bits) drives one write per cycle: `wr_addr=clr_cnt`, `wr_data_ptr=0`, `wr_data_ptr_val=0`.
  - The counter starts at 0.
  - When `clr_cnt==DEPTH-1`, the FSM moves to RUN. The counter does not wrap inside a clear.
- RUN:
  - `req_ready_o` is asserted to exactly one requester with `req_valid_i` set. The choice is round-robin: search starts at `last_grant+1` modulo `REQ_CNT`.
  - `last_grant` resets to `REQ_CNT-1`, so requester 0 has priority first.
  - `req_ready_o` is combinational from state, `last_grant` and `req_valid_i`. It is all-zero in CLEAR.
  - A transfer occurs when `req_valid_i[i] & req_ready_o[i]`.
  - On a transfer, the granted requester's addr/ptr/ptr_val are registered onto the write port with `wr_en=1`, and `last_grant` is set to i.
  - With no transfer, `wr_en=0`. `wr_addr`, `wr_data_ptr` and `wr_data_ptr_val` hold their last values.
- `init_done_o` is registered and equals 1 exactly when the state is RUN.
- `clear_i` in RUN:
  - Any transfer in the same cycle still completes.
  - The FSM enters CLEAR with `clr_cnt=0` on that edge.
- `clear_i` in CLEAR restarts the walk: `clr_cnt` goes to 0 on that edge, and the write issued for that cycle's old count still occurs.
- Requesters must hold their valid/data stable until ready is seen. The block does not check this.

## Timing
- Reset values:
  - State CLEAR, `clr_cnt=0`, `last_grant=REQ_CNT-1`.
  - `wr_en=0`, `wr_addr=0`, `wr_data_ptr=0`, `wr_data_ptr_val=0`.
  - `init_done_o=0`, `req_ready_o=0`.
- Let edge 0 be the first rising edge with `rst=0`.
  - After edge k (k=0..DEPTH-1): `wr_en=1`, `wr_addr=k`.
  - After edge DEPTH-1: state RUN, `init_done_o=1`. The last clear write is on the port in this same cycle.
- Requests are ready from the cycle after edge DEPTH-1. The first request write can appear after edge DEPTH, so there is no bubble and no overlap with the clear.
- Clear duration is exactly DEPTH cycles of `wr_en`, back to back.
- Request latency: transfer at edge n puts `wr_en=1` on the port after edge n.
- Throughput is one write per cycle; the port is fully shared.
- Fairness: with all requesters continuously valid, each is granted once every `REQ_CNT` cycles.
- `rst` asserted mid-clear or mid-RUN: the reset values above apply on that edge, and a full clear follows deassertion.
- Requests pending at `clear_i` see `req_ready_o=0` until `init_done_o` returns high.

## Test plan
Unless noted: `A_WIDTH=3` (DEPTH=8), `PTR_WIDTH=4`, `REQ_CNT=2`.
1. Reset, then release → 8 consecutive writes to addr 0..7 with ptr=0, ptr_val=0; `init_done_o` rises with the addr-7 write; `req_ready_o=0` throughout.
2. After init, req0 only, addr=5 ptr=0xA val=1 → `req_ready_o=01`; the next cycle `wr_en=1` addr=5 ptr=0xA ptr_val=1; then `wr_en=0`.
3. Both requesters valid continuously for 6 cycles → grants alternate 1,0,1,0,1,0 (last_grant=0 after test 2); the port shows six back-to-back writes carrying the matching data.
4. `clear_i` pulsed in the same cycle as a req1 transfer (addr=2) → the req1 write appears, then 8 clear writes addr 0..7; `init_done_o=0` during the clear; req0 held valid is not granted until `init_done_o=1`.
5. `clear_i` pulsed while the clear counter is at 4 → the write for addr 4 appears, then addr 0..7 again (13 clear writes total for that clear).
6. `rst` asserted for one cycle while req0 is being granted in RUN → outputs return to their reset values; that request produces no write; a full 8-write clear follows.
